sba_bus_master: RTL and testbench



---
 rtl/sba_bus_master_if.sv | 23 ++
 rtl/sba_bus_master.sv | 179 +++++++++++++++++
 tb/tb_sba_bus_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sba_bus_master_if.sv
// arilla_bus_if: single-cycle system bus between a master and memory-mapped slaves.
// Read data on data_in arrives on the cycle after the read strobe.
interface arilla_bus_if #(
  parameter int AddressWidth = 30
);
  logic [AddressWidth-1:0] address;
  logic [31:0]             data;
  logic [3:0]              byte_enable;
  logic                    read;
  logic                    write;
  logic [31:0]             data_in;
  logic                    intercept;

  modport master (
    output address, data, byte_enable, read, write,
    input  data_in
  );

  modport slave (
    input  address, data, byte_enable, read, write,
    output data_in, intercept
  );
endinterface

// File: rtl/sba_bus_master.sv
// Debug system-bus-access master: turns one SBA request into one sized, lane-steered
// arilla_bus_if cycle (with grant timeout) and returns exactly one response.
module sba_bus_master #(
  parameter int AddressWidth  = 30,
  parameter int TimeoutCycles = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth+1:0] req_address,
  input  logic [1:0]              req_size,
  input  logic [31:0]             req_wdata,
  input  logic                    req_autoinc,
  output logic                    rsp_valid,
  output logic                    rsp_error,
  output logic [31:0]             rsp_rdata,
  output logic [AddressWidth+1:0] rsp_address,
  output logic                    busy,
  output logic                    bus_request,
  input  logic                    bus_grant,
  arilla_bus_if.master            bus_interface
);

  localparam int ByteAw   = AddressWidth + 2;
  localparam int CntWidth = $clog2(TimeoutCycles + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARB     = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] FAIL    = 3'd4;

  logic [2:0]          state_reg;
  logic                write_reg;
  logic [ByteAw-1:0]   addr_reg;
  logic [1:0]          size_reg;
  logic [31:0]         wdata_reg;
  logic                autoinc_reg;
  logic [CntWidth-1:0] cnt_reg;
  logic                rsp_error_reg;
  logic [31:0]         rsp_rdata_reg;
  logic [ByteAw-1:0]   rsp_address_reg;

  logic                req_bad;
  logic                grant_cycle;
  logic                timeout_hit;
  logic [1:0]          lane;
  logic [3:0]          be_next;
  logic [31:0]         lanes_next;
  logic [31:0]         shifted;
  logic [31:0]         rdata_masked;
  logic [ByteAw-1:0]   next_addr;
  logic [ByteAw-1:0]   rsp_addr_ok;

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'd1:    req_bad = req_address[0];
      2'd2:    req_bad = (req_address[1:0] != 2'b00);
      2'd3:    req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  assign grant_cycle = (state_reg == ARB) && bus_grant;
  assign timeout_hit = (cnt_reg == CntWidth'(TimeoutCycles - 1));
  assign lane        = addr_reg[1:0];
  assign next_addr   = addr_reg + (ByteAw'(1) << size_reg);
  assign rsp_addr_ok = autoinc_reg ? next_addr : addr_reg;
  assign shifted     = bus_interface.data_in >> {lane, 3'b000};

  always_comb begin
    be_next      = 4'b1111;
    lanes_next   = wdata_reg;
    rdata_masked = shifted;
    case (size_reg)
      2'd0: begin
        be_next      = 4'b0001 << lane;
        lanes_next   = {4{wdata_reg[7:0]}};
        rdata_masked = {24'h0, shifted[7:0]};
      end
      2'd1: begin
        be_next      = 4'b0011 << lane;
        lanes_next   = {2{wdata_reg[15:0]}};
        rdata_masked = {16'h0, shifted[15:0]};
      end
      default: ;
    endcase
  end

  // Bus strobes exist only in the granted ARB cycle; write data is driven only for writes.
  always_comb begin
    bus_interface.read        = grant_cycle && !write_reg;
    bus_interface.write       = grant_cycle && write_reg;
    bus_interface.address     = '0;
    bus_interface.byte_enable = 4'b0000;
    bus_interface.data        = 32'h0;
    if (grant_cycle) begin
      bus_interface.address     = addr_reg[ByteAw-1:2];
      bus_interface.byte_enable = be_next;
      if (write_reg) begin
        bus_interface.data = lanes_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      write_reg       <= 1'b0;
      addr_reg        <= '0;
      size_reg        <= 2'd0;
      wdata_reg       <= 32'h0;
      autoinc_reg     <= 1'b0;
      cnt_reg         <= '0;
      rsp_error_reg   <= 1'b0;
      rsp_rdata_reg   <= 32'h0;
      rsp_address_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg   <= req_write;
            addr_reg    <= req_address;
            size_reg    <= req_size;
            wdata_reg   <= req_wdata;
            autoinc_reg <= req_autoinc;
            cnt_reg     <= '0;
            if (req_bad) begin
              state_reg       <= FAIL;
              rsp_error_reg   <= 1'b1;
              rsp_rdata_reg   <= 32'h0;
              rsp_address_reg <= req_address;
            end else begin
              state_reg <= ARB;
            end
          end
        end
        ARB: begin
          if (bus_grant) begin
            if (write_reg) begin
              state_reg       <= DONE;
              rsp_error_reg   <= 1'b0;
              rsp_rdata_reg   <= 32'h0;
              rsp_address_reg <= rsp_addr_ok;
            end else begin
              state_reg <= CAPTURE;
            end
          end else if (timeout_hit) begin
            state_reg       <= FAIL;
            rsp_error_reg   <= 1'b1;
            rsp_rdata_reg   <= 32'h0;
            rsp_address_reg <= addr_reg;
          end else begin
            cnt_reg <= cnt_reg + CntWidth'(1);
          end
        end
        CAPTURE: begin
          state_reg       <= DONE;
          rsp_error_reg   <= 1'b0;
          rsp_rdata_reg   <= rdata_masked;
          rsp_address_reg <= rsp_addr_ok;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign bus_request = (state_reg == ARB);
  assign rsp_valid   = (state_reg == DONE) || (state_reg == FAIL);
  assign rsp_error   = rsp_error_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_address = rsp_address_reg;

endmodule

// File: tb/tb_sba_bus_master.sv
// Directed bench for sba_bus_master: byte-level memory model plus per-cycle output check.
module tb_sba_bus_master;
  localparam int AW = 30;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW+1:0] req_address = '0;
  logic [1:0]    req_size = 2'd0;
  logic [31:0]   req_wdata = 32'h0;
  logic          req_autoinc = 1'b0;
  logic          rsp_valid, rsp_error;
  logic [31:0]   rsp_rdata;
  logic [AW+1:0] rsp_address;
  logic          busy, bus_request;
  logic          bus_grant = 1'b0;

  arilla_bus_if #(.AddressWidth(AW)) bus ();

  sba_bus_master #(.AddressWidth(AW), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_size(req_size), .req_wdata(req_wdata),
    .req_autoinc(req_autoinc),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .rsp_address(rsp_address), .busy(busy), .bus_request(bus_request),
    .bus_grant(bus_grant), .bus_interface(bus)
  );

  always #5 clk = ~clk;

  // Slave memory: one-cycle read latency, byte-enabled writes.
  logic [31:0] slave_mem [256];
  logic [31:0] rd_q = 32'h0;
  logic        rd_pend = 1'b0;
  always @(posedge clk) begin
    rd_pend <= bus.read;
    if (bus.read) rd_q <= slave_mem[bus.address[7:0]];
    if (bus.write)
      for (int l = 0; l < 4; l++)
        if (bus.byte_enable[l]) slave_mem[bus.address[7:0]][8*l +: 8] <= bus.data[8*l +: 8];
  end
  assign bus.data_in   = rd_pend ? rd_q : 32'h0;
  assign bus.intercept = 1'b0;

  // Reference model state and expectations for the current cycle.
  logic [31:0] model_mem [256];
  logic        e_ready, e_busy, e_req, e_rd, e_wr, e_rsp_v;
  logic [29:0] e_addr;
  logic [3:0]  e_be;
  logic [31:0] e_data;
  logic        e_err = 1'b0;
  logic [31:0] e_rdata = 32'h0;
  logic [31:0] e_raddr = 32'h0;

  int total = 0;
  int bad = 0;
  int req_hi = 0;
  logic [31:0] last_wr_data = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic [29:0] last_addr = '0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("bus_request", 32'(bus_request), 32'(e_req));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_v));
    chk("rsp_error", 32'(rsp_error), 32'(e_err));
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("rsp_address", rsp_address, e_raddr);
    chk("bus_read", 32'(bus.read), 32'(e_rd));
    chk("bus_write", 32'(bus.write), 32'(e_wr));
    chk("bus_address", 32'(bus.address), 32'(e_addr));
    chk("bus_be", 32'(bus.byte_enable), 32'(e_be));
    chk("bus_data", bus.data, e_data);
    if (bus_request === 1'b1) req_hi++;
    if (bus.write === 1'b1) begin
      last_wr_data = bus.data;
      last_be      = bus.byte_enable;
      last_addr    = bus.address;
    end
  end

  function automatic void exp_clear();
    e_ready = 1'b0; e_busy = 1'b0; e_req = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    e_rsp_v = 1'b0; e_addr = '0; e_be = 4'h0; e_data = 32'h0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] be = 4'h0;
    for (int i = 0; i < (1 << sz); i++) be[(a % 4) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_lanes(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] d = 32'h0;
    for (int l = 0; l < 4; l++) d[8*l +: 8] = wd[8*(l % (1 << sz)) +: 8];
    return d;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] b;
    for (int i = 0; i < (1 << sz); i++) begin
      b = a + 32'(i);
      model_mem[(b >> 2) & 255][8*(b % 4) +: 8] = wd[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] r = 32'h0;
    logic [31:0] b;
    for (int i = 0; i < (1 << sz); i++) begin
      b = a + 32'(i);
      r[8*i +: 8] = model_mem[(b >> 2) & 255][8*(b % 4) +: 8];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input bit ai, input int gdelay);
    bit illegal;
    bit granted;
    int k;
    illegal = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    exp_clear(); e_ready = 1'b1;
    req_valid = 1'b1; req_write = wr; req_address = a; req_size = sz;
    req_wdata = wd; req_autoinc = ai;
    step();
    req_valid = 1'b0;
    granted = 1'b0;
    k = 0;
    if (!illegal) begin
      while (!granted && k < TO) begin
        exp_clear(); e_busy = 1'b1; e_req = 1'b1;
        if (k >= gdelay) begin
          bus_grant = 1'b1;
          e_rd = !wr; e_wr = wr; e_addr = a[31:2]; e_be = model_be(a, sz);
          e_data = wr ? model_lanes(wd, sz) : 32'h0;
          granted = 1'b1;
        end else begin
          bus_grant = 1'b0;
        end
        step();
        if (!granted) k++;
      end
      bus_grant = 1'b0;
    end
    exp_clear(); e_busy = 1'b1;
    if (!granted) begin
      e_rsp_v = 1'b1; e_err = 1'b1; e_rdata = 32'h0; e_raddr = a;
    end else if (wr) begin
      model_write(a, sz, wd);
      e_rsp_v = 1'b1; e_err = 1'b0; e_rdata = 32'h0; e_raddr = ai ? a + (32'd1 << sz) : a;
    end else begin
      step();
      exp_clear(); e_busy = 1'b1;
      e_rsp_v = 1'b1; e_err = 1'b0; e_rdata = model_read(a, sz);
      e_raddr = ai ? a + (32'd1 << sz) : a;
    end
    step();
    exp_clear(); e_ready = 1'b1;
    $display("txn wr=%0d addr=%h size=%0d wdata=%h ai=%0d gdelay=%0d -> err=%0d rdata=%h raddr=%h",
             wr, a, sz, wd, ai, gdelay, rsp_error, rsp_rdata, rsp_address);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    exp_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    e_ready = 1'b1;
    step();

    do_req(1'b1, 32'h100, 2'd2, 32'hDEADBEEF, 1'b0, 0);
    chk("lit_wr_data", last_wr_data, 32'hDEADBEEF);
    chk("lit_wr_addr", 32'(last_addr), 32'h40);
    chk("lit_rsp_addr", rsp_address, 32'h100);

    do_req(1'b0, 32'h103, 2'd0, 32'h0, 1'b0, 0);
    chk("lit_byte_rd", rsp_rdata, 32'h000000DE);

    do_req(1'b1, 32'h102, 2'd1, 32'h00001234, 1'b1, 0);
    chk("lit_half_data", last_wr_data, 32'h12341234);
    chk("lit_half_be", 32'(last_be), 32'hC);
    chk("lit_half_autoinc", rsp_address, 32'h104);

    do_req(1'b0, 32'h100, 2'd2, 32'h0, 1'b0, 0);
    chk("lit_word_rd", rsp_rdata, 32'h1234BEEF);
    do_req(1'b0, 32'h102, 2'd1, 32'h0, 1'b0, 0);
    do_req(1'b0, 32'h101, 2'd0, 32'h0, 1'b1, 0);
    do_req(1'b1, 32'h081, 2'd0, 32'h000000A5, 1'b0, 0);
    do_req(1'b1, 32'h086, 2'd1, 32'h0000C3D2, 1'b1, 0);
    do_req(1'b0, 32'h080, 2'd2, 32'h0, 1'b0, 0);

    do_req(1'b0, 32'h101, 2'd2, 32'h0, 1'b0, 0);
    chk("lit_misalign_err", 32'(rsp_error), 32'h1);
    chk("lit_misalign_rdata", rsp_rdata, 32'h0);
    do_req(1'b0, 32'h103, 2'd1, 32'h0, 1'b1, 0);
    do_req(1'b1, 32'h100, 2'd3, 32'h11111111, 1'b1, 0);

    req_hi = 0;
    do_req(1'b1, 32'h200, 2'd2, 32'h55555555, 1'b1, 99);
    chk("lit_timeout_req_cycles", 32'(req_hi), 32'd4);
    chk("lit_timeout_raddr", rsp_address, 32'h200);
    do_req(1'b1, 32'h200, 2'd2, 32'hCAFEF00D, 1'b1, 2);
    chk("lit_late_grant_raddr", rsp_address, 32'h204);
    do_req(1'b0, 32'h200, 2'd2, 32'h0, 1'b0, 1);
    chk("lit_late_grant_rd", rsp_rdata, 32'hCAFEF00D);

    do_req(1'b1, 32'hFFFFFFFF, 2'd0, 32'h0000007E, 1'b1, 0);
    chk("lit_wrap", rsp_address, 32'h0);
    do_req(1'b0, 32'hFFFFFFFC, 2'd2, 32'h0, 1'b1, 0);

    // Reset while a word read sits in CAPTURE.
    exp_clear(); e_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h100; req_size = 2'd2;
    req_autoinc = 1'b0;
    step();
    req_valid = 1'b0;
    exp_clear(); e_busy = 1'b1; e_req = 1'b1; e_rd = 1'b1; e_addr = 30'h40; e_be = 4'hF;
    bus_grant = 1'b1;
    step();
    bus_grant = 1'b0;
    exp_clear();
    e_err = 1'b0; e_rdata = 32'h0; e_raddr = 32'h0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    e_ready = 1'b1;
    step();
    $display("txn reset during capture -> rsp_valid=%0d busy=%0d", rsp_valid, busy);
    do_req(1'b0, 32'h100, 2'd2, 32'h0, 1'b0, 0);
    chk("lit_after_reset_rd", rsp_rdata, 32'h1234BEEF);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
